// File: rtl/prog_counter_stack.sv
// Fetch-stage program counter with relative branch, absolute jump and
// call/return through a small hardware return-address stack.
module prog_counter_stack #(
  parameter int              PC_W      = 8,
  parameter int              OFF_W     = 6,
  parameter int              STK_DEPTH = 4,
  parameter logic [PC_W-1:0] RST_VEC   = '0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Cen,
  input  logic             Branch,
  input  logic [OFF_W-1:0] Offset,
  input  logic             Jump,
  input  logic             Call,
  input  logic             Ret,
  input  logic [PC_W-1:0]  Target,
  output logic [PC_W-1:0]  PCOut,
  output logic             StkFull,
  output logic             StkEmpty,
  output logic             StkErr
);

  localparam int SP_W  = $clog2(STK_DEPTH + 1);
  localparam int IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic             err_q, err_d;
  logic             push;
  logic [PC_W-1:0]  pc_inc;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [PC_W-1:0]  stk_q [STK_DEPTH];

  function automatic logic [PC_W-1:0] sext_off(input logic [OFF_W-1:0] off);
    logic signed [OFF_W-1:0] s;
    s = off;
    return PC_W'(s);
  endfunction

  assign pc_inc   = pc_q + PC_W'(1);
  assign wr_idx   = IDX_W'(sp_q);
  assign rd_idx   = IDX_W'(sp_q - SP_W'(1));
  assign StkFull  = (sp_q == SP_W'(STK_DEPTH));
  assign StkEmpty = (sp_q == '0);
  assign StkErr   = err_q;
  assign PCOut    = pc_q;

  // A faulting Ret/Call still consumes the cycle, so lower requests are dropped.
  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    err_d = err_q;
    push  = 1'b0;
    if (Cen) begin
      if (Ret) begin
        if (!StkEmpty) begin
          pc_d = stk_q[rd_idx];
          sp_d = sp_q - SP_W'(1);
        end else begin
          pc_d  = pc_inc;
          err_d = 1'b1;
        end
      end else if (Call) begin
        if (!StkFull) begin
          push = 1'b1;
          pc_d = Target;
          sp_d = sp_q + SP_W'(1);
        end else begin
          pc_d  = pc_inc;
          err_d = 1'b1;
        end
      end else if (Jump) begin
        pc_d = Target;
      end else if (Branch) begin
        pc_d = pc_q + sext_off(Offset);
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      pc_q  <= RST_VEC;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Stack contents are don't-care after reset; only the pointer is cleared.
  always_ff @(posedge Clk) begin
    if (Rst && push) stk_q[wr_idx] <= pc_inc;
  end

endmodule

// File: tb/tb_prog_counter_stack.sv
// Scoreboard bench for prog_counter_stack: directed scenarios followed by
// random requests, checked against a queue-based behavioural model.
module tb_prog_counter_stack;

  localparam int         PC_W      = 8;
  localparam int         OFF_W     = 6;
  localparam int         STK_DEPTH = 4;
  localparam logic [7:0] RST_VEC   = 8'h00;

  logic             Clk = 1'b0;
  logic             Rst = 1'b0;
  logic             Cen = 1'b0;
  logic             Branch = 1'b0;
  logic [OFF_W-1:0] Offset = '0;
  logic             Jump = 1'b0;
  logic             Call = 1'b0;
  logic             Ret = 1'b0;
  logic [PC_W-1:0]  Target = '0;
  logic [PC_W-1:0]  PCOut;
  logic             StkFull, StkEmpty, StkErr;

  prog_counter_stack #(
    .PC_W(PC_W), .OFF_W(OFF_W), .STK_DEPTH(STK_DEPTH), .RST_VEC(RST_VEC)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Cen(Cen), .Branch(Branch), .Offset(Offset),
    .Jump(Jump), .Call(Call), .Ret(Ret), .Target(Target),
    .PCOut(PCOut), .StkFull(StkFull), .StkEmpty(StkEmpty), .StkErr(StkErr)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [7:0] pc;
    logic       full;
    logic       empty;
    logic       err;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;

  // Behavioural model state
  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  logic       m_err;

  function automatic exp_t model_state();
    exp_t e;
    e.pc    = m_pc;
    e.full  = (m_stk.size() == STK_DEPTH);
    e.empty = (m_stk.size() == 0);
    e.err   = m_err;
    return e;
  endfunction

  task automatic drv(input logic rst, input logic cen, input logic ret,
                     input logic call, input logic jmp, input logic br,
                     input logic [5:0] off, input logic [7:0] tgt);
    int o;
    @(negedge Clk);
    Rst = rst; Cen = cen; Ret = ret; Call = call; Jump = jmp;
    Branch = br; Offset = off; Target = tgt;
    if (!rst) begin
      m_pc = RST_VEC;
      m_stk.delete();
      m_err = 1'b0;
    end else if (cen) begin
      if (ret) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin m_pc = 8'((int'(m_pc) + 1) % 256); m_err = 1'b1; end
      end else if (call) begin
        if (m_stk.size() < STK_DEPTH) begin
          m_stk.push_back(8'((int'(m_pc) + 1) % 256));
          m_pc = tgt;
        end else begin
          m_pc = 8'((int'(m_pc) + 1) % 256);
          m_err = 1'b1;
        end
      end else if (jmp) begin
        m_pc = tgt;
      end else if (br) begin
        o = off[5] ? int'(off) - 64 : int'(off);
        m_pc = 8'((int'(m_pc) + o + 256) % 256);
      end else begin
        m_pc = 8'((int'(m_pc) + 1) % 256);
      end
    end
    sb_q.push_back(model_state());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1, 1, 0, 0, 0, 0, 6'd0, 8'h00);
  endtask

  // Monitor: one architectural state per clock edge, popped after the edge.
  always @(posedge Clk) begin
    exp_t got, want;
    #1;
    cyc++;
    if (sb_q.size() > 0) begin
      want = sb_q.pop_front();
      got  = '{pc: PCOut, full: StkFull, empty: StkEmpty, err: StkErr};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL state cyc=%0d: got pc=%h full=%b empty=%b err=%b, want pc=%h full=%b empty=%b err=%b",
                 cyc, got.pc, got.full, got.empty, got.err,
                 want.pc, want.full, want.empty, want.err);
      end
    end
  end

  initial begin
    // Reset, then free-running count
    drv(0, 1, 0, 0, 0, 0, 6'd0, 8'h00);
    drv(0, 1, 0, 0, 0, 0, 6'd0, 8'h00);
    idle(5);
    // Branches and stall
    drv(1, 1, 0, 0, 1, 0, 6'd0, 8'h10);
    drv(1, 1, 0, 0, 0, 1, 6'h3D, 8'h00);
    drv(1, 1, 0, 0, 0, 1, 6'd31, 8'h00);
    for (int i = 0; i < 3; i++) drv(1, 0, 1, 1, 1, 1, 6'd5, 8'hEE);
    drv(1, 1, 0, 0, 0, 1, 6'd0, 8'h00);
    // Nested call / return
    drv(1, 1, 0, 0, 1, 0, 6'd0, 8'h20);
    drv(1, 1, 0, 1, 0, 0, 6'd0, 8'h80);
    drv(1, 1, 0, 1, 0, 0, 6'd0, 8'h90);
    drv(1, 1, 1, 0, 0, 0, 6'd0, 8'h00);
    drv(1, 1, 1, 0, 0, 0, 6'd0, 8'h00);
    // Fill, overflow, drain, underflow
    for (int i = 0; i < 4; i++) drv(1, 1, 0, 1, 0, 0, 6'd0, 8'hA0 + 8'(i));
    drv(1, 1, 0, 0, 1, 0, 6'd0, 8'h40);
    drv(1, 1, 0, 1, 0, 0, 6'd0, 8'hC0);
    for (int i = 0; i < 5; i++) drv(1, 1, 1, 0, 0, 0, 6'd0, 8'h00);
    // Priority: Ret wins over everything, then Jump over Branch
    drv(1, 1, 0, 0, 1, 0, 6'd0, 8'h32);
    drv(1, 1, 0, 1, 0, 0, 6'd0, 8'h70);
    drv(1, 1, 1, 1, 1, 1, 6'd7, 8'h99);
    drv(1, 1, 0, 0, 1, 1, 6'd7, 8'h55);
    // Wrap-around and reset during a call sequence
    drv(1, 1, 0, 0, 1, 0, 6'd0, 8'hFF);
    idle(1);
    drv(1, 1, 0, 0, 1, 0, 6'd0, 8'hFF);
    drv(1, 1, 0, 1, 0, 0, 6'd0, 8'h10);
    drv(1, 1, 1, 0, 0, 0, 6'd0, 8'h00);
    drv(1, 1, 0, 1, 0, 0, 6'd0, 8'h60);
    drv(0, 1, 0, 1, 0, 0, 6'd0, 8'h70);
    idle(2);
    // Random traffic
    for (int i = 0; i < 800; i++) begin
      drv(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 6) == 0), ($urandom_range(0, 3) == 0),
          6'($urandom), 8'($urandom));
    end
    @(negedge Clk);
    @(negedge Clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
